// File: rtl/tape_buf_pkg.sv
// Shared definitions for the tape-image buffer arbiter.
//   ADDR_W    : width of image offsets and SDRAM byte addresses
//   IDLE_DATA : byte returned to the player when no valid data exists
//   tape_state_e : arbiter FSM states
package tape_buf_pkg;

  localparam int unsigned ADDR_W    = 25;
  localparam logic [7:0]  IDLE_DATA = 8'hFF;

  typedef enum logic [1:0] {
    GAP,
    OPEN,
    RWAIT,
    WRITE
  } tape_state_e;

endpackage

// File: rtl/tape_wr_hold.sv
// One-entry holding register for ioctl download bytes.
// Captures a byte on each ioctl_wr during a download, flags bytes lost while
// the entry is still occupied, and tracks the image length (highest offset + 1).
// Ports:
//   clk_sys, reset          : clock, async active-high reset
//   ioctl_download, dl_rise : download level and its rising-edge pulse
//   ioctl_wr/addr/dout      : download strobe, offset and byte
//   hold_ack                : memory has committed the held byte this cycle
//   hold_full/addr/data     : holding register state
//   wr_overflow             : sticky lost-byte flag, cleared on dl_rise
//   max_addr                : image length seen so far
module tape_wr_hold
  import tape_buf_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              dl_rise,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              hold_ack,
  output logic              hold_full,
  output logic [ADDR_W-1:0] hold_addr,
  output logic [7:0]        hold_data,
  output logic              wr_overflow,
  output logic [ADDR_W-1:0] max_addr
);

  logic              strobe;
  logic              accept;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] max_base;

  always_comb begin
    strobe   = ioctl_download & ioctl_wr;
    // An ack in the same cycle frees the entry, so the new byte still fits.
    accept   = strobe & (~hold_full | hold_ack);
    // Length saturates at the top offset instead of wrapping to zero.
    end_addr = (ioctl_addr == '1) ? '1 : ioctl_addr + ADDR_W'(1);
    max_base = dl_rise ? '0 : max_addr;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_full   <= 1'b0;
      hold_addr   <= '0;
      hold_data   <= '0;
      wr_overflow <= 1'b0;
      max_addr    <= '0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        hold_addr <= ioctl_addr;
        hold_data <= ioctl_dout;
      end else if (hold_ack) begin
        hold_full <= 1'b0;
      end

      if (dl_rise)
        wr_overflow <= 1'b0;
      if (strobe && !accept)
        wr_overflow <= 1'b1;

      if (accept)
        max_addr <= (end_addr > max_base) ? end_addr : max_base;
      else if (dl_rise)
        max_addr <= '0;
    end
  end

endmodule

// File: rtl/tape_buffer_arb.sv
// Tape-image buffer arbiter: owns the image in SDRAM, writes download bytes,
// measures the image size and serves the player's slotted byte reads.
// Ports:
//   clk_sys, reset                 : clock, async active-high reset
//   ioctl_download/wr/addr/dout    : download interface
//   tape_rd_en, tape_rd, tape_addr : player slot, request and offset
//   tape_din                       : byte returned, valid from the first
//                                    rd_en-low cycle after a read
//   tape_size, size_valid          : image length of the last download
//   mem_req/we/addr/wdata          : SDRAM byte-port request (held until ack)
//   mem_ack, mem_rdata             : SDRAM completion and read data
//   wr_overflow, rd_error          : sticky lost-byte / read-timeout flags
module tape_buffer_arb
  import tape_buf_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       GAP_CYCLES  = 4,
  parameter int unsigned       OPEN_CYCLES = 8,
  parameter int unsigned       MEM_TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              tape_rd_en,
  input  logic              tape_rd,
  input  logic [ADDR_W-1:0] tape_addr,
  output logic [7:0]        tape_din,
  output logic [ADDR_W-1:0] tape_size,
  output logic              size_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              wr_overflow,
  output logic              rd_error
);

  localparam int unsigned CNT_W = 16;

  tape_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic              dl_q;
  logic              size_pend;
  logic              dl_rise;
  logic              dl_fall;
  logic              hold_ack;
  logic              hold_full;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0]        hold_data;
  logic [ADDR_W-1:0] max_addr;

  always_comb begin
    dl_rise  = ioctl_download & ~dl_q;
    dl_fall  = ~ioctl_download & dl_q;
    hold_ack = (state == WRITE) & mem_ack;
  end

  tape_wr_hold u_wr_hold (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .dl_rise        (dl_rise),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .hold_ack       (hold_ack),
    .hold_full      (hold_full),
    .hold_addr      (hold_addr),
    .hold_data      (hold_data),
    .wr_overflow    (wr_overflow),
    .max_addr       (max_addr)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= GAP;
      cnt        <= '0;
      tape_rd_en <= 1'b0;
      tape_din   <= IDLE_DATA;
      tape_size  <= '0;
      size_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_error   <= 1'b0;
      dl_q       <= 1'b0;
      size_pend  <= 1'b0;
    end else begin
      dl_q <= ioctl_download;

      // Size is published only after the held byte has been committed, so
      // size_valid never rises while the last write is still in flight.
      if (dl_rise) begin
        size_valid <= 1'b0;
        rd_error   <= 1'b0;
        size_pend  <= 1'b0;
      end else if (dl_fall) begin
        size_pend <= 1'b1;
      end else if (size_pend && !hold_full) begin
        tape_size  <= max_addr;
        size_valid <= 1'b1;
        size_pend  <= 1'b0;
      end

      case (state)
        GAP: begin
          if (hold_full) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + hold_addr;
            mem_wdata <= hold_data;
          end else if (ioctl_download) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state      <= OPEN;
            tape_rd_en <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        OPEN: begin
          if (ioctl_download) begin
            state      <= GAP;
            tape_rd_en <= 1'b0;
            cnt        <= '0;
          end else if (tape_rd) begin
            state    <= RWAIT;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR + tape_addr;
            cnt      <= '0;
          end else if (cnt == CNT_W'(OPEN_CYCLES - 1)) begin
            state      <= GAP;
            tape_rd_en <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // rd_en stays high here so it falls together with tape_din updating.
        RWAIT: begin
          if (mem_ack) begin
            tape_din   <= mem_rdata;
            mem_req    <= 1'b0;
            tape_rd_en <= 1'b0;
            state      <= GAP;
            cnt        <= '0;
          end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            tape_din   <= IDLE_DATA;
            mem_req    <= 1'b0;
            rd_error   <= 1'b1;
            tape_rd_en <= 1'b0;
            state      <= GAP;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= GAP;
            cnt     <= '0;
          end
        end

        default: begin
          state      <= GAP;
          tape_rd_en <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tape_buffer_arb.sv
`timescale 1ns/1ps
module tb_tape_buffer_arb;

  localparam logic [24:0] BASE = 25'h0001000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        tape_rd_en;
  logic        tape_rd;
  logic [24:0] tape_addr;
  logic [7:0]  tape_din;
  logic [24:0] tape_size;
  logic        size_valid;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        wr_overflow;
  logic        rd_error;

  int total = 0;
  int bad   = 0;

  // memory responder controls and write log
  int          ack_lat  = 2;
  bit          ack_en   = 1'b1;
  logic [7:0]  rd_value = 8'h00;
  int          lat_cnt  = 0;
  int          wr_cnt   = 0;
  logic [24:0] wlog_addr [0:15];
  logic [7:0]  wlog_data [0:15];

  always #5 clk_sys = ~clk_sys;

  tape_buffer_arb #(
    .BASE_ADDR   (BASE),
    .GAP_CYCLES  (4),
    .OPEN_CYCLES (8),
    .MEM_TIMEOUT (255)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .tape_rd_en     (tape_rd_en),
    .tape_rd        (tape_rd),
    .tape_addr      (tape_addr),
    .tape_din       (tape_din),
    .tape_size      (tape_size),
    .size_valid     (size_valid),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .wr_overflow    (wr_overflow),
    .rd_error       (rd_error)
  );

  // SDRAM model: acks the ack_lat-th cycle of a held request.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk_sys);
      mem_ack = 1'b0;
      if (reset !== 1'b0 || mem_req !== 1'b1) begin
        lat_cnt = 0;
      end else begin
        lat_cnt++;
        if (ack_en && lat_cnt >= ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_value;
          if (mem_we === 1'b1) begin
            if (wr_cnt < 16) begin
              wlog_addr[wr_cnt] = mem_addr;
              wlog_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
          end
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic wait_rd_en_high(input string name);
    int n;
    n = 0;
    while (tape_rd_en !== 1'b1 && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (tape_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL %s: tape_rd_en got=%b want=1 within 40 cycles", name, tape_rd_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    total++;
    if ({tape_rd_en, mem_req, mem_we, size_valid, wr_overflow, rd_error} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=000000",
               {tape_rd_en, mem_req, mem_we, size_valid, wr_overflow, rd_error});
    end
    total++;
    if ({tape_din, tape_size, mem_addr, mem_wdata} !== {8'hFF, 25'h0, 25'h0, 8'h00}) begin
      bad++;
      $display("FAIL reset_data: din=%h size=%h addr=%h wdata=%h want FF/0/0/0",
               tape_din, tape_size, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_download();
    int w0;
    int n;
    logic [7:0] exp_b;
    w0      = wr_cnt;
    ack_lat = 2;
    ack_en  = 1'b1;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    total++;
    if (size_valid !== 1'b0) begin
      bad++;
      $display("FAIL dl_size_valid_low: got=%b want=0", size_valid);
    end
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = (i == 0) ? 8'h13 : 8'h00;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      n = 0;
      while (wr_cnt < w0 + i + 1 && n < 20) begin
        @(negedge clk_sys);
        n++;
      end
      total++;
      if (wr_cnt != w0 + i + 1) begin
        bad++;
        $display("FAIL dl_write_%0d: writes got=%0d want=%0d", i, wr_cnt - w0, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_b = (i == 0) ? 8'h13 : 8'h00;
      total++;
      if ({wlog_addr[w0+i], wlog_data[w0+i]} !== {BASE + 25'(i), exp_b}) begin
        bad++;
        $display("FAIL dl_log_%0d: addr=%h data=%h want addr=%h data=%h",
                 i, wlog_addr[w0+i], wlog_data[w0+i], BASE + 25'(i), exp_b);
      end
    end
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b0;
    n = 0;
    while (size_valid !== 1'b1 && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if ({size_valid, tape_size, wr_overflow} !== {1'b1, 25'd3, 1'b0}) begin
      bad++;
      $display("FAIL dl_size: valid=%b size=%0d ovf=%b want 1/3/0",
               size_valid, tape_size, wr_overflow);
    end
  endtask

  task automatic test_read();
    int n;
    int low;
    bit hold_ok;
    wait_rd_en_high("rd_slot_open");
    rd_value  = 8'h5A;
    ack_lat   = 5;
    tape_addr = 25'd1;
    tape_rd   = 1'b1;
    @(negedge clk_sys);
    tape_rd = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, BASE + 25'd1}) begin
      bad++;
      $display("FAIL rd_req: req=%b we=%b addr=%h want 1/0/%h",
               mem_req, mem_we, mem_addr, BASE + 25'd1);
    end
    hold_ok = 1'b1;
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      if (tape_rd_en !== 1'b1) hold_ok = 1'b0;
      n++;
      @(negedge clk_sys);
    end
    total++;
    if (n != 5 || !hold_ok) begin
      bad++;
      $display("FAIL rd_wait: req_cycles=%0d rd_en_held=%b want 5/1", n, hold_ok);
    end
    total++;
    if ({tape_rd_en, tape_din} !== {1'b0, 8'h5A}) begin
      bad++;
      $display("FAIL rd_data: rd_en=%b din=%h want 0/5A", tape_rd_en, tape_din);
    end
    low = 0;
    while (tape_rd_en === 1'b0 && low < 20) begin
      low++;
      @(negedge clk_sys);
    end
    total++;
    if (low != 4 || tape_din !== 8'h5A) begin
      bad++;
      $display("FAIL rd_gap: low_cycles=%0d din=%h want 4/5A", low, tape_din);
    end
    ack_lat = 2;
  endtask

  task automatic test_idle_slots();
    int n;
    int hi;
    int lo;
    bit req_seen;
    n = 0;
    while (tape_rd_en !== 1'b0 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    wait_rd_en_high("idle_sync");
    req_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hi = 0;
      while (tape_rd_en === 1'b1 && hi < 30) begin
        if (mem_req !== 1'b0) req_seen = 1'b1;
        hi++;
        @(negedge clk_sys);
      end
      lo = 0;
      while (tape_rd_en === 1'b0 && lo < 30) begin
        if (mem_req !== 1'b0) req_seen = 1'b1;
        lo++;
        @(negedge clk_sys);
      end
      total++;
      if (hi != 8 || lo != 4) begin
        bad++;
        $display("FAIL idle_period_%0d: high=%0d low=%0d want 8/4", k, hi, lo);
      end
    end
    total++;
    if (req_seen) begin
      bad++;
      $display("FAIL idle_no_req: mem_req seen=1 want 0");
    end
  endtask

  task automatic test_overflow();
    int w0;
    int n;
    int extra;
    w0     = wr_cnt;
    ack_en = 1'b0;
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
    ioctl_addr = 25'd5; ioctl_dout = 8'hAA; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    ioctl_addr = 25'd6; ioctl_dout = 8'hBB; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    total++;
    if (wr_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag: got=%b want=1", wr_overflow);
    end
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, BASE + 25'd5, 8'hAA}) begin
      bad++;
      $display("FAIL ovf_req: req=%b we=%b addr=%h wdata=%h want 1/1/%h/AA",
               mem_req, mem_we, mem_addr, mem_wdata, BASE + 25'd5);
    end
    ack_lat = 1;
    ack_en  = 1'b1;
    n = 0;
    while (wr_cnt == w0 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    @(negedge clk_sys);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req !== 1'b0) extra++;
      @(negedge clk_sys);
    end
    total++;
    if (wr_cnt != w0 + 1 || extra != 0 ||
        {wlog_addr[w0], wlog_data[w0]} !== {BASE + 25'd5, 8'hAA}) begin
      bad++;
      $display("FAIL ovf_single_write: writes=%0d extra_req=%0d addr=%h data=%h want 1/0/%h/AA",
               wr_cnt - w0, extra, wlog_addr[w0], wlog_data[w0], BASE + 25'd5);
    end
    ioctl_download = 1'b0;
    n = 0;
    while (size_valid !== 1'b1 && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if ({size_valid, tape_size, wr_overflow} !== {1'b1, 25'd6, 1'b1}) begin
      bad++;
      $display("FAIL ovf_size: valid=%b size=%0d ovf=%b want 1/6/1",
               size_valid, tape_size, wr_overflow);
    end
    ack_lat = 2;
  endtask

  task automatic test_timeout();
    int n;
    ack_en = 1'b0;
    wait_rd_en_high("to_slot_open");
    tape_addr = 25'd2;
    tape_rd   = 1'b1;
    @(negedge clk_sys);
    tape_rd = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 400) begin
      n++;
      @(negedge clk_sys);
    end
    total++;
    if (n != 255) begin
      bad++;
      $display("FAIL to_req_cycles: got=%0d want=255", n);
    end
    total++;
    if ({mem_req, tape_din, rd_error} !== {1'b0, 8'hFF, 1'b1}) begin
      bad++;
      $display("FAIL to_result: req=%b din=%h rd_error=%b want 0/FF/1",
               mem_req, tape_din, rd_error);
    end
    wait_rd_en_high("to_slots_resume");
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int low;
    ack_en = 1'b0;
    wait_rd_en_high("rst_slot_open");
    tape_addr = 25'd3;
    tape_rd   = 1'b1;
    @(negedge clk_sys);
    tape_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if ({mem_req, tape_rd_en} !== 2'b11) begin
      bad++;
      $display("FAIL rst_pre_rwait: req=%b rd_en=%b want 1/1", mem_req, tape_rd_en);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({mem_req, tape_rd_en} !== 2'b00) begin
      bad++;
      $display("FAIL rst_async_drop: req=%b rd_en=%b want 0/0", mem_req, tape_rd_en);
    end
    total++;
    if ({tape_din, tape_size, size_valid, wr_overflow, rd_error, mem_we, mem_addr} !==
        {8'hFF, 25'h0, 1'b0, 1'b0, 1'b0, 1'b0, 25'h0}) begin
      bad++;
      $display("FAIL rst_values: din=%h size=%h sv=%b ovf=%b rderr=%b we=%b addr=%h",
               tape_din, tape_size, size_valid, wr_overflow, rd_error, mem_we, mem_addr);
    end
    @(negedge clk_sys);
    ack_en = 1'b1;
    reset  = 1'b0;
    low = 0;
    while (tape_rd_en === 1'b0 && low < 20) begin
      low++;
      @(negedge clk_sys);
    end
    total++;
    if (low != 4) begin
      bad++;
      $display("FAIL rst_resume: low_cycles=%0d want 4", low);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tape_rd        = 1'b0;
    tape_addr      = '0;
    test_reset();
    test_download();
    test_read();
    test_idle_slots();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tape_buffer_arb.md
Name: tape_buffer_arb

Overview:
Upstream memory front-end for the tape player. It owns the tape-image buffer in SDRAM and sits between the ioctl download path, the SDRAM byte port and the tape player's slotted read interface (rd_en / rd / addr / din). During a download it writes image bytes and measures the image size. Otherwise it opens read slots for the player and returns one byte per slot, with a guaranteed data-valid timing.

Parameters:
BASE_ADDR, 25'h0, SDRAM byte address of image byte 0.
GAP_CYCLES, 4, clk_sys cycles tape_rd_en is held low between slots (must be >=2).
OPEN_CYCLES, 8, cycles a slot stays open waiting for tape_rd before closing unused.
MEM_TIMEOUT, 255, max cycles waiting for mem_ack before a read is abandoned.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download in progress
ioctl_wr  in  1  one-cycle strobe: ioctl_dout valid for ioctl_addr
ioctl_addr  in  25  image byte offset
ioctl_dout  in  8  image byte
tape_rd_en  out  1  read slot open (to player rd_en)
tape_rd  in  1  player read request (player rd, already gated by rd_en)
tape_addr  in  25  image offset requested by player
tape_din  out  8  byte returned to player
tape_size  out  25  image length in bytes, valid after download
size_valid  out  1  high while tape_size describes a completed download
mem_req  out  1  SDRAM request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; stable while mem_req
mem_addr  out  25  BASE_ADDR + offset
mem_wdata  out  8  write data
mem_ack  in  1  one-cycle completion; mem_rdata valid in same cycle
mem_rdata  in  8  read data
wr_overflow  out  1  sticky: ioctl byte lost
rd_error  out  1  sticky: read abandoned on timeout

Behaviour:
- Reset values (asynchronous): tape_rd_en=0, tape_din=8'hFF, tape_size=0, size_valid=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_overflow=0, rd_error=0. Write holding register is empty and the FSM is in GAP with counter=0.
- FSM states:
  - GAP: tape_rd_en=0. Counts GAP_CYCLES, then goes to OPEN. If a write is pending, goes to WRITE first. When ioctl_download=1 it never leaves GAP except for WRITE.
  - OPEN: tape_rd_en=1. In the first cycle with tape_rd=1, latches tape_addr, drives mem_req=1, mem_we=0, mem_addr=BASE_ADDR+tape_addr, and goes to RWAIT. If no tape_rd within OPEN_CYCLES, goes to GAP. If ioctl_download rises, goes to GAP next cycle.
  - RWAIT: tape_rd_en stays 1. On mem_ack: tape_din<=mem_rdata, mem_req<=0, go to GAP, so tape_rd_en falls in the cycle after the ack. tape_din is therefore valid in the first rd_en-low cycle and held until the next read completes. If MEM_TIMEOUT cycles elapse without ack: mem_req<=0, tape_din<=8'hFF, rd_error<=1, go to GAP.
  - WRITE: mem_req=1, mem_we=1, mem_addr=BASE_ADDR+held addr, mem_wdata=held byte. On mem_ack the holding register empties and the FSM goes to GAP.
- Write capture:
  - One-entry holding register, loaded on ioctl_wr whenever ioctl_download=1.
  - ioctl_wr while the holding register is full and not being acked in the same cycle: the new byte is dropped and wr_overflow<=1.
  - A simultaneous ack and new strobe is accepted.
- Size tracking:
  - On ioctl_download rise: size_valid<=0, max<=0, wr_overflow<=0, rd_error<=0.
  - Each accepted write: max<=max(max, ioctl_addr+1), 25-bit with no wrap.
  - On ioctl_download fall: tape_size<=max and size_valid<=1 once the holding register has drained (the last byte is committed before size_valid rises).
- Read/download collision: a read already in RWAIT completes normally before any WRITE is issued. mem_req is never dropped before mem_ack, except on timeout.
- Reset mid-transfer: mem_req deasserts immediately. The pending write is discarded.

Decomposition:
- Package tape_buf_pkg holds:
  - the FSM state enum (GAP, OPEN, RWAIT, WRITE);
  - the ADDR_W=25 constant;
  - the idle-data constant 8'hFF.
- One natural sub-module: tape_wr_hold, the one-entry ioctl holding register with its overflow flag and max-address tracker.

Test Plan:
- Download of 3 bytes {0x13,0x00,0x00} at offsets 0..2, mem_ack 2 cycles after each req -> three writes at BASE_ADDR+0..2, tape_size=3, size_valid=1 after ioctl_download falls, wr_overflow=0.
- After download, player pulses rd with tape_addr=1, memory returns 0x5A after 5 cycles -> tape_rd_en held high through RWAIT, falls the cycle after the ack, tape_din=0x5A on that low cycle, next slot opens after exactly 4 low cycles.
- No tape_rd for 8 open cycles -> tape_rd_en low for 4, high for 8, repeating, with mem_req never asserted.
- Two ioctl_wr strobes 1 cycle apart with mem_ack withheld -> second byte dropped, wr_overflow=1, only the first write reaches memory.
- Read with mem_ack never returned -> after 255 cycles mem_req=0, tape_din=0xFF, rd_error=1, slots resume.
- Reset asserted during RWAIT -> mem_req and tape_rd_en drop asynchronously, all outputs at reset values, normal slotting after release.
